// File: rtl/mem_arb_if.sv
// Bus bundle between the SISC requesters (fetch, data), the memory model and mem_arb.
// The arbiter attaches through the slave modport; the environment drives through master.
interface mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb.sv
// Unified-memory arbiter for SISC: fetch vs data path, one outstanding access at a time.
// Define MEM_ARB_STATS_EN to add saturating grant/stall statistics outputs.
module mem_arb #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arb_if.slave      bus,
    output logic          busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_if,
    output logic [15:0]   stat_dm,
    output logic [15:0]   stat_stall
`endif
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] starve_cnt;
    logic          win_if;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          load;
    logic          capture;
    logic          pick_if;

    assign pick_if = bus.if_req && (!bus.dm_req || starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (bus.if_req || bus.dm_req) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                state_nxt = WAIT;
                cnt_nxt   = CW'(MEM_LAT - 1);
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            win_if     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                win_if   <= pick_if;
                lat_we   <= !pick_if && bus.dm_we;
                lat_addr <= pick_if ? bus.if_addr : bus.dm_addr;
                if (!pick_if)
                    lat_wdata <= bus.dm_wdata;
            end
            // A dropped fetch request forgets any accumulated starvation.
            if (!bus.if_req)
                starve_cnt <= '0;
            else if (load) begin
                if (pick_if)
                    starve_cnt <= '0;
                else if (starve_cnt != SW'(STARVE_MAX))
                    starve_cnt <= starve_cnt + 1'b1;
            end
            if (capture && !lat_we) begin
                if (win_if)
                    if_rdata_q <= bus.mem_rdata;
                else
                    dm_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = (state == ACCESS) && win_if;
    assign bus.dm_gnt    = (state == ACCESS) && !win_if;
    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.if_rvalid = (state == RESP) && win_if;
    assign bus.dm_rvalid = (state == RESP) && !win_if;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign busy          = (state != IDLE);

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_if    <= '0;
            stat_dm    <= '0;
            stat_stall <= '0;
        end else begin
            if (bus.if_gnt && stat_if != '1)
                stat_if <= stat_if + 1'b1;
            if (bus.dm_gnt && stat_dm != '1)
                stat_dm <= stat_dm + 1'b1;
            if ((bus.if_req || bus.dm_req) && !(bus.if_gnt || bus.dm_gnt) && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb (MEM_LAT=2, STARVE_MAX=4) with a two-stage memory read model.
// Define MEM_ARB_STATS_EN for both files to also check the statistics counters.
module tb_mem_arb;
    localparam logic [6:0] IG = 7'b1000000;
    localparam logic [6:0] DG = 7'b0100000;
    localparam logic [6:0] EN = 7'b0010000;
    localparam logic [6:0] WE = 7'b0001000;
    localparam logic [6:0] IR = 7'b0000100;
    localparam logic [6:0] DR = 7'b0000010;
    localparam logic [6:0] BZ = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    mem_arb_if #(.AW(16), .DW(32)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_if, stat_dm, stat_stall;
`endif

    mem_arb #(.AW(16), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if    (stat_if),
        .stat_dm    (stat_dm),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: read data is valid exactly two cycles after the mem_en cycle.
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [15:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        v1 <= bus.mem_en && !bus.mem_we;
        a1 <= bus.mem_addr;
        v2 <= v1;
        a2 <= a1;
    end

    function automatic logic [31:0] lookup(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        if (a == 16'h0020) return 32'hCAFE0020;
        return {16'hA5A5, a};
    endfunction

    assign bus.mem_rdata = v2 ? lookup(a2) : 32'hBAD0BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int c, input logic [6:0] exp);
        logic [6:0] st;
        st = {bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.if_rvalid, bus.dm_rvalid, busy};
        check($sformatf("%s status c%0d", tag, c), {25'd0, st}, {25'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] exp;
        int k, ph;
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        repeat (3) @(negedge clk);
        chk_st("reset", 0, 7'd0);
        check("reset if_rdata", bus.if_rdata, 32'h0);
        check("reset dm_rdata", bus.dm_rdata, 32'h0);
        check("reset mem_addr", {16'd0, bus.mem_addr}, 32'h0);
        check("reset mem_wdata", bus.mem_wdata, 32'h0);
        check("reset starve", {29'd0, dut.starve_cnt}, 32'h0);
        rst = 0;
        @(negedge clk);

        // Simultaneous fetch + load: data first, then fetch.
        for (int c = 0; c <= 9; c++) begin
            exp = 7'd0;
            if (c == 1) exp = DG | EN | BZ;
            if (c == 2 || c == 3 || c == 6 || c == 7) exp = BZ;
            if (c == 4) exp = DR | BZ;
            if (c == 5) exp = IG | EN | BZ;
            if (c == 8) exp = IR | BZ;
            chk_st("simul", c, exp);
            if (c == 1) check("simul mem_addr", {16'd0, bus.mem_addr}, 32'h0020);
            if (c == 4) check("simul dm_rdata", bus.dm_rdata, 32'hCAFE0020);
            if (c == 5) check("simul fetch addr", {16'd0, bus.mem_addr}, 32'h0010);
            if (c == 8) check("simul if_rdata", bus.if_rdata, 32'hDEADBEEF);
`ifdef MEM_ARB_STATS_EN
            if (c == 9) begin
                check("stat_dm", {16'd0, stat_dm}, 32'd1);
                check("stat_if", {16'd0, stat_if}, 32'd1);
                check("stat_stall", {16'd0, stat_stall}, 32'd4);
            end
`endif
            if (c == 0) begin
                bus.if_req = 1; bus.if_addr = 16'h0010;
                bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h0020;
            end
            if (c == 1) bus.dm_req = 0;
            if (c == 5) bus.if_req = 0;
            @(negedge clk);
        end

        // Single fetch.
        for (int c = 0; c <= 5; c++) begin
            exp = 7'd0;
            if (c == 1) exp = IG | EN | BZ;
            if (c == 2 || c == 3) exp = BZ;
            if (c == 4) exp = IR | BZ;
            chk_st("fetch", c, exp);
            if (c == 1) check("fetch mem_addr", {16'd0, bus.mem_addr}, 32'h0010);
            if (c == 4) check("fetch if_rdata", bus.if_rdata, 32'hDEADBEEF);
            if (c == 0) begin bus.if_req = 1; bus.if_addr = 16'h0010; end
            if (c == 1) bus.if_req = 0;
            @(negedge clk);
        end

        // Starvation: both requests held; fetch wins the fifth arbitration.
        for (int c = 0; c <= 21; c++) begin
            exp = 7'd0;
            if (c >= 1 && c <= 20) begin
                k  = (c - 1) / 4;
                ph = (c - 1) % 4;
                if (ph == 0) exp = ((k < 4) ? DG : IG) | EN | BZ;
                else if (ph == 3) exp = ((k < 4) ? DR : IR) | BZ;
                else exp = BZ;
            end
            chk_st("starve", c, exp);
            if (c == 13) check("starve cnt at max", {29'd0, dut.starve_cnt}, 32'd4);
            if (c == 16) check("starve dm_rdata", bus.dm_rdata, 32'hA5A50030);
            if (c == 17) check("starve cnt cleared", {29'd0, dut.starve_cnt}, 32'd0);
            if (c == 0) begin
                bus.if_req = 1; bus.if_addr = 16'h0010;
                bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h0030;
            end
            if (c == 17) begin bus.if_req = 0; bus.dm_req = 0; end
            @(negedge clk);
        end

        // Store: single mem_we cycle, completion ack, dm_rdata untouched.
        for (int c = 0; c <= 5; c++) begin
            exp = 7'd0;
            if (c == 1) exp = DG | EN | WE | BZ;
            if (c == 2 || c == 3) exp = BZ;
            if (c == 4) exp = DR | BZ;
            chk_st("store", c, exp);
            if (c == 1) begin
                check("store mem_addr", {16'd0, bus.mem_addr}, 32'h0020);
                check("store mem_wdata", bus.mem_wdata, 32'h12345678);
            end
            if (c == 5) check("store dm_rdata kept", bus.dm_rdata, 32'hA5A50030);
            if (c == 0) begin
                bus.dm_req = 1; bus.dm_we = 1;
                bus.dm_addr = 16'h0020; bus.dm_wdata = 32'h12345678;
            end
            if (c == 1) begin bus.dm_req = 0; bus.dm_we = 0; end
            @(negedge clk);
        end

        // Reset during WAIT abandons the fetch; a later fetch runs normally.
        for (int c = 0; c <= 9; c++) begin
            exp = 7'd0;
            if (c == 1 || c == 5) exp = IG | EN | BZ;
            if (c == 2 || c == 6 || c == 7) exp = BZ;
            if (c == 8) exp = IR | BZ;
            chk_st("rstmid", c, exp);
            if (c == 3) begin
                check("rstmid mem_addr", {16'd0, bus.mem_addr}, 32'h0);
                check("rstmid mem_wdata", bus.mem_wdata, 32'h0);
                check("rstmid if_rdata", bus.if_rdata, 32'h0);
                check("rstmid dm_rdata", bus.dm_rdata, 32'h0);
            end
            if (c == 8) check("rstmid if_rdata", bus.if_rdata, 32'hA5A50050);
            if (c == 0) begin bus.if_req = 1; bus.if_addr = 16'h0040; end
            if (c == 1) bus.if_req = 0;
            if (c == 2) rst = 1;
            if (c == 3) rst = 0;
            if (c == 4) begin bus.if_req = 1; bus.if_addr = 16'h0050; end
            if (c == 5) bus.if_req = 0;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
